// File: rtl/iic_init_seq.sv
// iic_init_seq -- register-initialisation sequencer for the shared I2C master.
//
// Walks an external table of {reg_addr[15:0], data[7:0]} entries and turns
// each one into a single-byte I2C write request to iic_ctrl. Entries whose
// address is 16'hFFFF are delay entries (data x DLY_UNIT cycles). Failed
// writes (NACK or timeout) are retried up to RETRY_MAX attempts before the
// sequence aborts and reports the failing index.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle pulse, (re)runs the table from index 0 when idle
//   lut_index       table address (table has 1-cycle read latency)
//   lut_data        {reg_addr, data} of the addressed entry
//   w_req / r_req   write request pulse to the controller / read request (0)
//   device_id, reg_addr, addr_mode, w_num, wr_data   transfer description
//   wr_done, ack    completion pulse and NACK flag (ack=1 means failure)
//   busy, init_done, err, err_index   sequence status
module iic_init_seq #(
  parameter logic [7:0] DEV_ID     = 8'h78,
  parameter int         ADDR_MODE  = 1,
  parameter int         LUT_SIZE   = 64,
  parameter int         PWR_DLY    = 50000,
  parameter int         DLY_UNIT   = 1000,
  parameter int         RETRY_MAX  = 3,
  parameter int         TIMEOUT    = 200000,
  parameter int         AUTO_START = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        w_req,
  output logic        r_req,
  output logic [7:0]  device_id,
  output logic [15:0] reg_addr,
  output logic        addr_mode,
  output logic [15:0] w_num,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        ack,
  output logic        busy,
  output logic        init_done,
  output logic        err,
  output logic [7:0]  err_index
);

  // One shared counter serves the power-up wait, delay entries and the
  // write timeout; it is sized for the largest of the three.
  localparam int DLY_MAX  = 255 * DLY_UNIT;
  localparam int CNT_MAX0 = (PWR_DLY > DLY_MAX) ? PWR_DLY : DLY_MAX;
  localparam int CNT_MAX  = (TIMEOUT > CNT_MAX0) ? TIMEOUT : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int ATT_W    = $clog2(RETRY_MAX + 1);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'((PWR_DLY > 0) ? PWR_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [7:0]       LAST_INDEX = 8'(LUT_SIZE - 1);
  localparam logic [ATT_W-1:0] ATT_LIMIT  = ATT_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PWR_WAIT, ST_FETCH, ST_ISSUE, ST_WAIT_DONE, ST_DELAY, ST_DONE, ST_FAIL
  } state_t;

  state_t            state_reg, state_next;
  logic              phase_reg, phase_next;       // 0 = address cycle, 1 = data cycle of FETCH
  logic [7:0]        index_reg, index_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ATT_W-1:0]  attempt_reg, attempt_next;
  logic [15:0]       reg_addr_reg, reg_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic              busy_reg, busy_next;
  logic              init_done_reg, init_done_next;
  logic              err_reg, err_next;
  logic [7:0]        err_index_reg, err_index_next;
  logic              advance, fail;
  logic [CNT_W-1:0]  dly_total;

  assign dly_total = CNT_W'(lut_data[7:0]) * CNT_W'(DLY_UNIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= (AUTO_START != 0) ? ST_PWR_WAIT : ST_IDLE;
      phase_reg     <= 1'b0;
      index_reg     <= '0;
      cnt_reg       <= '0;
      attempt_reg   <= '0;
      reg_addr_reg  <= '0;
      wr_data_reg   <= '0;
      busy_reg      <= 1'b0;
      init_done_reg <= 1'b0;
      err_reg       <= 1'b0;
      err_index_reg <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      index_reg     <= index_next;
      cnt_reg       <= cnt_next;
      attempt_reg   <= attempt_next;
      reg_addr_reg  <= reg_addr_next;
      wr_data_reg   <= wr_data_next;
      busy_reg      <= busy_next;
      init_done_reg <= init_done_next;
      err_reg       <= err_next;
      err_index_reg <= err_index_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    index_next     = index_reg;
    cnt_next       = cnt_reg;
    attempt_next   = attempt_reg;
    reg_addr_next  = reg_addr_reg;
    wr_data_next   = wr_data_reg;
    busy_next      = busy_reg;
    init_done_next = init_done_reg;
    err_next       = err_reg;
    err_index_next = err_index_reg;
    advance        = 1'b0;
    fail           = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          index_next     = '0;
          init_done_next = 1'b0;
          err_next       = 1'b0;
          err_index_next = '0;
          busy_next      = 1'b1;
          phase_next     = 1'b0;
          state_next     = ST_FETCH;
        end
      end
      ST_PWR_WAIT: begin
        if (cnt_reg >= PWR_LAST) begin
          cnt_next   = '0;
          index_next = '0;
          busy_next  = 1'b1;
          phase_next = 1'b0;
          state_next = ST_FETCH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_FETCH: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next   = 1'b0;
          attempt_next = '0;
          if (lut_data[23:8] == 16'hFFFF) begin
            // The delay is measured from the start of this entry, so its own
            // two fetch cycles count towards it. Anything that fits inside
            // the fetch advances straight away.
            if (dly_total <= CNT_W'(2)) begin
              advance = 1'b1;
            end else begin
              cnt_next   = dly_total - CNT_W'(3);
              state_next = ST_DELAY;
            end
          end else begin
            reg_addr_next = (ADDR_MODE != 0) ? lut_data[23:8] : {8'h00, lut_data[15:8]};
            wr_data_next  = lut_data[7:0];
            state_next    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        attempt_next = attempt_reg + 1'b1;
        cnt_next     = '0;
        state_next   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A timeout behaves like a NACK arriving in the TIMEOUT-th waiting
        // cycle; the counter stops there, so it can never wrap.
        if (wr_done) begin
          if (ack) fail = 1'b1;
          else     advance = 1'b1;
        end else if (cnt_reg >= TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_reg == '0) advance = 1'b1;
        else               cnt_next = cnt_reg - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    if (fail) begin
      if (attempt_reg < ATT_LIMIT) begin
        state_next = ST_ISSUE;
      end else begin
        state_next     = ST_FAIL;
        err_next       = 1'b1;
        err_index_next = index_reg;
        busy_next      = 1'b0;
      end
    end

    if (advance) begin
      if (index_reg == LAST_INDEX) begin
        state_next     = ST_DONE;
        init_done_next = 1'b1;
        busy_next      = 1'b0;
      end else begin
        index_next = index_reg + 8'd1;
        phase_next = 1'b0;
        state_next = ST_FETCH;
      end
    end
  end

  assign lut_index = index_reg;
  assign w_req     = (state_reg == ST_ISSUE);
  assign r_req     = 1'b0;
  assign device_id = DEV_ID;
  assign addr_mode = (ADDR_MODE != 0);
  assign w_num     = 16'd1;
  assign reg_addr  = reg_addr_reg;
  assign wr_data   = wr_data_reg;
  assign busy      = busy_reg;
  assign init_done = init_done_reg;
  assign err       = err_reg;
  assign err_index = err_index_reg;

endmodule
